icache_sa: RTL
==============

Name: icache_sa

Overview:
- Parametrised set-associative instruction cache.
- Generalises the direct-mapped I-cache to configurable sets, line width and associativity, with per-set round-robin replacement.
- Has an autonomous line-refill engine on the 32-bit external bus and a single-cycle index invalidate for CACHE-op support.
- Sits between the fetch stage (virtual index, physical tag from the ITLB) and the external memory arbiter.

Parameters:
SETS, 512, number of sets; power of 2, >=2
LINEW, 256, line width in bits; power of 2, multiple of 32, >=64
WAYS, 2, associativity; power of 2, >=1
PAW, 32, physical address width
Derived values:
- WORDS = LINEW/32
- OFFB = log2(LINEW/8)
- IDXB = log2(SETS)
- TAGW = PAW-OFFB-IDXB

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
req  in  1  lookup request, sampled when busy=0
va  in  64  fetch virtual address; index = va[OFFB+IDXB-1:OFFB], word = va[OFFB-1:2]
pa  in  PAW  physical address from ITLB, same cycle as req; tag = pa[PAW-1:OFFB+IDXB]
rvalid  out  1  response valid
hit  out  1  response is a hit; qualifies instr
instr  out  32  instruction word
busy  out  1  refill or invalidate in progress; req/inval ignored
inval  in  1  index-invalidate request, sampled when busy=0
inval_va  in  64  address whose set is invalidated
extreq  out  1  external line read request
extaddr  out  PAW  line-aligned physical address (low OFFB bits zero)
extdata  in  32  refill word
extack  in  1  extdata valid this cycle

Behaviour:
- Reset (async on rstn=0): rvalid=0, hit=0, instr=0, busy=0, extreq=0, extaddr=0. All valid bits are cleared, all round-robin pointers are 0, state=IDLE. Reset mid-refill aborts it: extreq drops at once, the partial line is discarded and no valid bit is set.
- States: IDLE, LOOK, FILL, DONE.

IDLE:
- inval=1 takes priority over req in the same cycle; the req is dropped with no rvalid.
- On inval: clear valid of all ways in set(inval_va) and reset that set's pointer. Takes one cycle; busy=1 during that cycle; stay IDLE.
- On req=1: latch index, word, tag, and line-aligned pa; go to LOOK.

LOOK (cycle N+1 after req):
- Compare the tag against all valid ways.
- Any match: rvalid=1, hit=1, instr=word of the lowest-numbered matching way; return to IDLE. A new req may be accepted in this cycle (busy=0), giving 1 response per cycle on back-to-back hits.
- No match: rvalid=1, hit=0; go to FILL.

FILL:
- busy=1, extreq=1, extaddr=latched line address. All held until the last ack.
- Each cycle with extack=1 stores extdata into word k of the line buffer, k=0..WORDS-1 ascending. Gaps between acks are allowed.
- extack while extreq=0 is ignored.
- On the WORDS-th ack: write the line, tag and valid into the victim way; advance the set pointer mod WAYS; extreq=0 next cycle; go to DONE.
- Victim choice: lowest-numbered invalid way, else the way at the set pointer. WAYS=1 always selects way 0.

DONE:
- One cycle with rvalid=1, hit=1, instr=requested word, busy=1; then IDLE.
- A lookup to the same line issued after DONE hits.

General rules:
- rvalid is a single-cycle pulse per accepted req, never asserted otherwise.
- instr holds its last value when rvalid=0.
- No hit-under-miss and no request queueing; the requester re-issues after busy falls.

Test Plan:
1. Reset; req va=0x80001004 pa=0x1004 -> LOOK rvalid=1 hit=0; extreq=1, extaddr=0x1000; ack words 0xA0..0xA7 back-to-back -> DONE rvalid=1 hit=1 instr=0xA1; then req pa=0x1008 -> next cycle hit=1, instr=0xA2.
2. WAYS=2, defaults: fill 0x1000 and 0x5000 (both index 0x80) -> both hit. Fill 0x9000 -> evicts way 0; 0x1000 misses and 0x5000 still hits.
3. Acks with 3-cycle gaps -> extreq and busy held across gaps; req pulsed mid-fill produces no rvalid; final line is correct.
4. After filling 0x1000: inval inval_va=0x1000 -> busy=1 for 1 cycle; next req pa=0x1000 -> hit=0. Same-cycle inval+req -> no rvalid.
5. rstn=0 after 3 acks of a fill -> extreq=0 immediately. After release, req pa=0x1000 misses and no stale words are returned.
6. WAYS=1, SETS=64, LINEW=128: fill 0x0000, then 0x0400 (same index) -> 0x0000 misses again, confirming direct-mapped eviction.

Source files
------------

// File: rtl/icache_sa.sv
// Set-associative instruction cache with per-set round-robin replacement,
// an autonomous 32-bit line-refill engine and a one-cycle set invalidate.
module icache_sa #(
    parameter int SETS  = 512,
    parameter int LINEW = 256,
    parameter int WAYS  = 2,
    parameter int PAW   = 32
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           req,
    input  logic [63:0]    va,
    input  logic [PAW-1:0] pa,
    output logic           rvalid,
    output logic           hit,
    output logic [31:0]    instr,
    output logic           busy,
    input  logic           inval,
    input  logic [63:0]    inval_va,
    output logic           extreq,
    output logic [PAW-1:0] extaddr,
    input  logic [31:0]    extdata,
    input  logic           extack
);

    localparam int WORDS = LINEW / 32;
    localparam int OFFB  = $clog2(LINEW / 8);
    localparam int IDXB  = $clog2(SETS);
    localparam int TAGW  = PAW - OFFB - IDXB;
    localparam int WRDW  = $clog2(WORDS);
    localparam int PTRW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, LOOK, FILL, DONE} state_t;
    typedef logic [WORDS-1:0][31:0] line_t;

    state_t            state_q, state_d;
    logic              rvalid_q, rvalid_d;
    logic              hit_q, hit_d;
    logic [31:0]       instr_q, instr_d;
    logic              busy_q, busy_d;
    logic              extreq_q, extreq_d;
    logic [PAW-1:0]    extaddr_q, extaddr_d;
    logic [IDXB-1:0]   idx_q, idx_d;
    logic [WRDW-1:0]   wrd_q, wrd_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [WRDW-1:0]   cnt_q, cnt_d;
    line_t             line_buf_q, line_buf_d;

    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][PTRW-1:0] rr_q;
    logic [TAGW-1:0]           tag_mem  [SETS][WAYS];
    line_t                     data_mem [SETS][WAYS];

    logic [IDXB-1:0] va_idx, inv_idx;
    logic [WRDW-1:0] va_wrd;
    logic [TAGW-1:0] pa_tag;
    logic            lk_hit;
    logic [PTRW-1:0] lk_way, victim, rr_nxt;
    logic [31:0]     lk_word;
    line_t           new_line;
    logic            fill_we, inv_en;
    logic            unused_bits;

    assign va_idx  = va[OFFB+IDXB-1:OFFB];
    assign va_wrd  = va[OFFB-1:2];
    assign pa_tag  = pa[PAW-1:OFFB+IDXB];
    assign inv_idx = inval_va[OFFB+IDXB-1:OFFB];
    assign unused_bits = ^{va[63:OFFB+IDXB], va[1:0], pa[OFFB-1:0],
                           inval_va[63:OFFB+IDXB], inval_va[OFFB-1:0]};

    // Descending scan so the lowest-numbered matching way wins.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[va_idx][w] && tag_mem[va_idx][w] == pa_tag) begin
                lk_hit = 1'b1;
                lk_way = PTRW'(w);
            end
        end
        lk_word = data_mem[va_idx][lk_way][va_wrd];
    end

    always_comb begin
        victim = rr_q[idx_q];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_q][w]) victim = PTRW'(w);
        end
        rr_nxt = (WAYS == 1) ? '0 : rr_q[idx_q] + 1'b1;
    end

    always_comb begin
        new_line        = line_buf_q;
        new_line[cnt_q] = extdata;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        rvalid_d   = 1'b0;
        hit_d      = 1'b0;
        instr_d    = instr_q;
        busy_d     = busy_q;
        extreq_d   = extreq_q;
        extaddr_d  = extaddr_q;
        idx_d      = idx_q;
        wrd_d      = wrd_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        line_buf_d = line_buf_q;
        fill_we    = 1'b0;
        inv_en     = 1'b0;
        unique case (state_q)
            IDLE, LOOK: begin
                if (state_q == LOOK && !hit_q) begin
                    state_d  = FILL;
                    extreq_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (!busy_q && inval) begin
                        inv_en = 1'b1;
                        busy_d = 1'b1;
                    end else if (!busy_q && req) begin
                        state_d   = LOOK;
                        rvalid_d  = 1'b1;
                        hit_d     = lk_hit;
                        busy_d    = !lk_hit;
                        if (lk_hit) instr_d = lk_word;
                        idx_d     = va_idx;
                        wrd_d     = va_wrd;
                        tag_d     = pa_tag;
                        extaddr_d = {pa[PAW-1:OFFB], {OFFB{1'b0}}};
                    end
                end
            end
            FILL: begin
                if (extreq_q && extack) begin
                    line_buf_d = new_line;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == WRDW'(WORDS - 1)) begin
                        fill_we  = 1'b1;
                        extreq_d = 1'b0;
                        rvalid_d = 1'b1;
                        hit_d    = 1'b1;
                        instr_d  = new_line[wrd_q];
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rvalid_q   <= 1'b0;
            hit_q      <= 1'b0;
            instr_q    <= '0;
            busy_q     <= 1'b0;
            extreq_q   <= 1'b0;
            extaddr_q  <= '0;
            idx_q      <= '0;
            wrd_q      <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            line_buf_q <= '0;
            valid_q    <= '0;
            rr_q       <= '0;
        end else begin
            state_q    <= state_d;
            rvalid_q   <= rvalid_d;
            hit_q      <= hit_d;
            instr_q    <= instr_d;
            busy_q     <= busy_d;
            extreq_q   <= extreq_d;
            extaddr_q  <= extaddr_d;
            idx_q      <= idx_d;
            wrd_q      <= wrd_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            line_buf_q <= line_buf_d;
            if (fill_we) begin
                valid_q[idx_q][victim] <= 1'b1;
                rr_q[idx_q]            <= rr_nxt;
            end
            if (inv_en) begin
                valid_q[inv_idx] <= '0;
                rr_q[inv_idx]    <= '0;
            end
        end
    end

    // NOTE: tag/data arrays are not reset; valid_q alone decides whether a way holds data.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[idx_q][victim]  <= tag_q;
            data_mem[idx_q][victim] <= new_line;
        end
    end

    assign rvalid  = rvalid_q;
    assign hit     = hit_q;
    assign instr   = instr_q;
    assign busy    = busy_q;
    assign extreq  = extreq_q;
    assign extaddr = extaddr_q;

endmodule
